// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states and
// the shift kinds understood by the single-step shifter.
package alu_pkg;

    // Operation codes. For the x-codes the base value (bit 0 cleared) is given.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_OR   = 4'b1100;
    localparam logic [3:0] ALU_AND  = 4'b1110;

    // Width of the shift amount field taken from op_b.
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SH_LEFT      = 2'b00,
        SH_RIGHT_LOG = 2'b01,
        SH_RIGHT_ARI = 2'b10
    } shift_kind_t;

endpackage

// File: rtl/alu_secuencial_desplazador_paso.sv
// One combinational shift step: moves the working value by 0..SHIFT_STEP
// positions in the requested direction, filling with zeros or the sign bit.
module desplazador_paso
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1,
    parameter int AW         = $clog2(SHIFT_STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AW-1:0]    amount,
    input  shift_kind_t      kind,
    output logic [WIDTH-1:0] result
);

    // Select the shift flavour; unknown kinds pass the data through unchanged.
    always_comb begin
        result = data;
        case (kind)
            SH_LEFT:      result = data << amount;
            SH_RIGHT_LOG: result = data >> amount;
            SH_RIGHT_ARI: result = WIDTH'($signed(data) >>> amount);
            default:      result = data;
        endcase
    end

endmodule

// File: rtl/alu_secuencial.sv
// Sequential ALU for the execute stage. Logic, add/sub and compare finish in
// one cycle; shifts iterate SHIFT_STEP bits per cycle. resultado and cero are
// registered and held until the next completion.
module alu_secuencial
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       sel_alu,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resultado,
    output logic             cero
);

    localparam int AW = $clog2(SHIFT_STEP + 1);

    state_t               state;
    shift_kind_t          kind;
    logic [WIDTH-1:0]     work;
    logic [SHAMT_W-1:0]   remaining;

    logic [3:0]           base;
    logic [SHAMT_W-1:0]   shamt;
    logic                 is_shift;
    shift_kind_t          start_kind;
    logic [WIDTH-1:0]     imm_result;
    logic [AW-1:0]        step;
    logic [SHAMT_W-1:0]   remaining_next;
    logic [WIDTH-1:0]     step_result;

    assign base  = {sel_alu[3:1], 1'b0};
    assign shamt = op_b[SHAMT_W-1:0];

    // Decode the operation and compute every single-cycle result directly
    // from the live inputs; a zero-amount shift simply returns op_a.
    always_comb begin
        imm_result = op_a;
        is_shift   = 1'b0;
        start_kind = SH_LEFT;
        case (base)
            ALU_ADD:  imm_result = sel_alu[0] ? (op_a - op_b) : (op_a + op_b);
            ALU_SLL: begin
                is_shift   = 1'b1;
                start_kind = SH_LEFT;
            end
            ALU_SLT:  imm_result = ($signed(op_a) < $signed(op_b)) ?
                                   {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            ALU_SLTU: imm_result = (op_a < op_b) ?
                                   {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            ALU_XOR:  imm_result = op_a ^ op_b;
            ALU_SRL: begin
                is_shift   = 1'b1;
                start_kind = sel_alu[0] ? SH_RIGHT_ARI : SH_RIGHT_LOG;
            end
            ALU_OR:   imm_result = op_a | op_b;
            ALU_AND:  imm_result = op_a & op_b;
            default:  imm_result = op_a;
        endcase
    end

    // Amount moved this cycle is min(SHIFT_STEP, remaining).
    always_comb begin
        if (remaining >= SHAMT_W'(SHIFT_STEP)) begin
            step = AW'(SHIFT_STEP);
        end else begin
            step = remaining[AW-1:0];
        end
        remaining_next = remaining - SHAMT_W'(step);
    end

    desplazador_paso #(
        .WIDTH      (WIDTH),
        .SHIFT_STEP (SHIFT_STEP),
        .AW         (AW)
    ) u_paso (
        .data   (work),
        .amount (step),
        .kind   (kind),
        .result (step_result)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            kind      <= SH_LEFT;
            work      <= {WIDTH{1'b0}};
            remaining <= {SHAMT_W{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            resultado <= {WIDTH{1'b0}};
            cero      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        if (is_shift && (shamt != {SHAMT_W{1'b0}})) begin
                            work      <= op_a;
                            remaining <= shamt;
                            kind      <= start_kind;
                            busy      <= 1'b1;
                            state     <= ST_SHIFT;
                        end else begin
                            resultado <= imm_result;
                            cero      <= (imm_result == {WIDTH{1'b0}});
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    work      <= step_result;
                    remaining <= remaining_next;
                    if (remaining_next == {SHAMT_W{1'b0}}) begin
                        resultado <= step_result;
                        cero      <= (step_result == {WIDTH{1'b0}});
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // start is ignored here; the caller may retry next cycle.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
- Execution unit that consumes the 4-bit `sel_alu` code produced by the ALU control decoder.
- Executes the operation on two operands under a start/done handshake.
- Logic, add/sub and compare operations complete in one cycle. Shifts are iterative, `SHIFT_STEP` bits per cycle, to save area.
- Sits in the execute stage of the multi-cycle RV32I core. Also supplies the `cero` flag for branch resolution.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHIFT_STEP, 1, bit positions shifted per cycle in the SHIFT state; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only when busy=0.
- sel_alu  input  4  operation code, captured with start.
- op_a  input  WIDTH  first operand, captured with start.
- op_b  input  WIDTH  second operand, captured with start; shift amount = op_b[4:0].
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; resultado valid in this cycle.
- resultado  output  WIDTH  registered result.
- cero  output  1  registered flag, resultado == 0.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, resultado=0, cero=1. Any in-flight operation is discarded.
- sel_alu decode, with x meaning bit 0 ignored:
  - 0000 ADD; 0001 SUB.
  - 001x SLL.
  - 010x SLT (signed); 011x SLTU.
  - 100x XOR.
  - 1010 SRL; 1011 SRA.
  - 110x OR; 111x AND.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^WIDTH.
  - SLT and SLTU return 1 or 0, zero-extended.
  - SRA replicates op_a[WIDTH-1].
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 captures sel_alu, op_a, op_b.
  - Non-shift op, or shift with shamt=0: compute and register resultado at the end of this cycle, then go to DONE.
  - Shift with shamt>0: load the working register with op_a and the remaining count with shamt, then go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT:
  - Each cycle, shift the working register by min(SHIFT_STEP, remaining) and decrement remaining by the same amount.
  - When remaining reaches 0 after the update, write resultado and go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Latency, start accepted at cycle N:
  - Non-shift op or shamt=0: done at cycle N+1.
  - Shift with shamt k>0: done at cycle N+1+ceil(k/SHIFT_STEP). SHIFT_STEP=1, k=31 gives done at N+32.
- busy:
  - Asserted in the SHIFT state only.
  - start while busy=1 or in DONE is ignored, with no queueing.
  - Back-to-back: start may be asserted in the cycle after done; it is accepted in IDLE.
- Output hold:
  - resultado and cero are updated only at completion.
  - They hold their value until the next completion, so the caller may read them after done.
- Inputs sel_alu, op_a and op_b may change freely after capture without effect.
- Branch use: the decoder issues 0001, 0101 or 0111; `cero` then gives eq/ne and lt/ge directly from resultado.

Decomposition:
- Shared package alu_pkg:
  - Localparams for every sel_alu code: ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_SRL=4'b1010, ALU_SRA=4'b1011, plus the base codes for the x-codes (ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND).
  - State encoding for IDLE, SHIFT, DONE.
  - Shift-kind encoding: left, logical right, arithmetic right.
- One natural sub-module, desplazador_paso:
  - Combinational single step: shifts the working register by a 0..SHIFT_STEP amount in a given direction/kind.
  - Instantiated once.
- The remaining datapath and FSM stay in alu_secuencial.

Test Plan:
- Reset mid-shift: start SLL, a=1, b=20; assert rst at cycle N+5 → busy=0, done=0, resultado=0, cero=1 immediately. After release, the start ignored during rst produces no done.
- Single-cycle ops:
  - 0000, a=0xFFFFFFFF, b=1 → done at N+1, resultado=0, cero=1.
  - 0001, a=5, b=7 → resultado=0xFFFFFFFE.
  - 0101, a=0x80000000, b=1 → resultado=1.
  - 0111, same operands → resultado=0.
- Shifts with SHIFT_STEP=1:
  - 1011, a=0x80000000, b=31 → done at N+32, resultado=0xFFFFFFFF.
  - 1010, same operands → resultado=1.
  - 0010, a=3, b=0 → done at N+1, resultado=3.
- Handshake:
  - start held high through a shift a=1, b=4 → exactly one done, at N+5; result 0x10.
  - New start in the cycle after done is accepted.
  - Operand changes during SHIFT have no effect.
- Branch codes: 0001 with a=b=0x1234 → cero=1; 0001 with a=0x1234, b=0x1235 → cero=0. resultado holds for 10 idle cycles.
- SHIFT_STEP=4: 0010, a=1, b=10 → done at N+4 (ceil(10/4)=3), resultado=0x400. Random regression against a reference model with SHIFT_STEP=1, 2, 4, 8.
